quadrature_decoder: RTL
=======================

# quadrature_decoder

Input-side companion to the up/down counter: converts a mechanical rotary encoder's two quadrature phases (A, B) into debounced single-cycle step pulses with direction, plus a wrapping position count. It sits between the board pins and the display/counter logic. Its `dir` and `step` outputs drive the counter's up/down control directly, and `count` can feed the segment decoder. All logic runs on the 100 MHz board clock; there is no derived clock.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required before a phase change is accepted (1 ms at 100 MHz). Legal range is ≥ 2.
- `COUNT_W`, default 4: width of the position counter.

- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `a_in`  in  1  encoder phase A, asynchronous to `clk`.
- `b_in`  in  1  encoder phase B, asynchronous to `clk`.
- `step`  out  1  one-cycle pulse per accepted legal transition.
- `dir`  out  1  direction of the last legal step: 1 = up, 0 = down. Holds its value between steps.
- `count`  out  COUNT_W  position. Steps by ±1 per legal transition and wraps modulo 2^COUNT_W.
- `err`  out  1  one-cycle pulse when both debounced phases change in the same cycle.

## Operation
- **Synchronizer.** Each phase passes through a 2-flop synchronizer, which gives `a_s`/`b_s`.
- **Debouncer, per phase.** The debouncer holds an accepted value `x_db` and a stability counter.
  - While `x_s == x_db`, the counter is 0.
  - While `x_s != x_db`, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES−1 with `x_s` still different, `x_db <= x_s` and the counter returns to 0.
  - Any return of `x_s` to `x_db` before then clears the counter. A glitch shorter than DEBOUNCE_CYCLES is therefore discarded.
- **Priming.**
  - Reset clears `primed`.
  - While `primed` is 0, the debounced state is loaded as `prev = {a_s,b_s}` with no `step` or `err`.
  - `primed` sets once DEBOUNCE_CYCLES cycles have elapsed after reset deasserts.
  - This prevents a spurious event when the encoder rests at any position other than 00 at power-up.
- **Transition classification, once primed.** Each cycle compares `cur = {a_db,b_db}` against `prev`, then sets `prev <= cur`.
  - Up sequence: 00→10→11→01→00 (A leads B). On each of these, `step` = 1, `dir` = 1, `count` + 1.
  - Down sequence: the reverse order. On each of these, `step` = 1, `dir` = 0, `count` − 1.
  - Both bits differ (00↔11, 10↔01): `err` = 1, `count` and `dir` unchanged, `prev` still updated.
  - No change: no pulse.
- **Resolution.** Every legal edge counts, giving 4 counts per detent cycle.
- **Count arithmetic.** Modulo 2^COUNT_W: up from all-ones gives 0; down from 0 gives all-ones.
- **Reset mid-operation.** Clears the synchronizers, debouncers, `prev`, `primed` and all outputs on the next edge. Any transition in flight is dropped.

## Timing
- **Reset values:** `step` = 0, `err` = 0, `dir` = 0, `count` = 0. Synchronizer flops, `a_db`, `b_db` and `prev` all 0.
- **Latency.** If `a_in` changes before edge k and stays stable:
  - `a_s` updates at edge k+1.
  - `a_db` updates at edge k+1+DEBOUNCE_CYCLES.
  - `step`/`err` are high, and `count`/`dir` are updated, for exactly the one cycle after edge k+2+DEBOUNCE_CYCLES.
- **Register timing.** `step`, `err`, `dir` and `count` are registered outputs. `step` and `err` are never both high.
- **Speed limit.** Minimum input dwell per phase state is DEBOUNCE_CYCLES cycles. Faster rotation is filtered or reported via `err`, never miscounted silently as a legal step in the wrong direction.

## Structure
- Shared package `quad_pkg` holds:
  - localparams for the four Gray states (S00, S10, S11, S01);
  - a function `classify(prev, cur)` returning NONE / UP / DOWN / ILLEGAL.
- Sub-module `debounce_sync` contains the 2-flop synchronizer, the stability counter and `x_db`. It is parameterised by DEBOUNCE_CYCLES and instantiated once per phase.
- The top level holds the priming logic, `prev`, the classifier and the output registers.

## Test plan
All benches run with DEBOUNCE_CYCLES = 4 and COUNT_W = 4. Each phase state is held for 12 cycles unless stated.
1. **Reset and priming.** Assert `reset` for 3 cycles with `a_in`=`b_in`=1, then run 20 cycles → `count` = 0, `dir` = 0, no `step`/`err` pulse at any time.
2. **Forward rotation.** From 00, drive 10, 11, 01, 00 → four 1-cycle `step` pulses, each 7 cycles after its input change; `dir` = 1; `count` = 4. Continue 12 more up transitions → `count` wraps to 0.
3. **Reverse rotation with wrap.** From `count` = 0 at state 00, drive 01 → one `step`, `dir` = 0, `count` = 15.
4. **Glitch rejection.** Pulse `a_in` high for 3 cycles, then low → no `step`, `a_db` stays 0, `count` unchanged. Repeat with a 4-cycle pulse → accepted: `count` + 1, then − 1 when A returns low.
5. **Illegal transition.** At 00, switch `a_in` and `b_in` together to 11 → exactly one `err` pulse, no `step`, `count` unchanged. Then drive 01 → `step`, `dir` = 1.
6. **Reset mid-operation.** At `count` = 7, assert `reset` while an A edge is being debounced → `count` = 0 after the next edge, no `step` emitted for the in-flight edge, re-priming required.

Source files
------------

// File: rtl/quad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | quad_pkg : Gray states and transition classifier for quadrature decoding  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package quad_pkg;

   localparam logic [1:0] S00 = 2'b00;
   localparam logic [1:0] S10 = 2'b10;
   localparam logic [1:0] S11 = 2'b11;
   localparam logic [1:0] S01 = 2'b01;

   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_UP      = 2'd1,
      EV_DOWN    = 2'd2,
      EV_ILLEGAL = 2'd3
   } event_t;

   function automatic logic [1:0] next_up(input logic [1:0] s);
      case (s)
         S00:     return S10;
         S10:     return S11;
         S11:     return S01;
         default: return S00;
      endcase
   endfunction

   // Bits are {A,B}; the up direction is A leading B.
   function automatic event_t classify(input logic [1:0] prev, input logic [1:0] cur);
      if (prev == cur)
         return EV_NONE;
      else if ((prev ^ cur) == 2'b11)
         return EV_ILLEGAL;
      else if (next_up(prev) == cur)
         return EV_UP;
      else
         return EV_DOWN;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_sync : 2-flop synchronizer plus stability-counter debouncer      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic x_in,
   input  logic load,
   output logic x_s,
   output logic x_db
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             meta;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         x_s  <= 1'b0;
         x_db <= 1'b0;
         cnt  <= '0;
      end else begin
         meta <= x_in;
         x_s  <= meta;
         // load bypasses filtering so the accepted value can track the pins while priming
         if (load) begin
            x_db <= x_s;
            cnt  <= '0;
         end else if (x_s == x_db) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            x_db <= x_s;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | quadrature_decoder : debounced encoder phases to step/dir pulses + count  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module quadrature_decoder
   import quad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int COUNT_W         = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a_in,
   input  logic               b_in,
   output logic               step,
   output logic               dir,
   output logic [COUNT_W-1:0] count,
   output logic               err
);

   // The synchronized phases are valid two edges after reset; a shorter
   // priming window (only possible at DEBOUNCE_CYCLES = 2) would load stale zeros.
   localparam int PRIME_CYCLES = (DEBOUNCE_CYCLES < 3) ? 3 : DEBOUNCE_CYCLES;
   localparam int PRIME_W      = $clog2(PRIME_CYCLES);

   logic               primed;
   logic               loading;
   logic [PRIME_W-1:0] prime_cnt;
   logic               a_s;
   logic               b_s;
   logic               a_db;
   logic               b_db;
   logic [1:0]         prev;
   logic [1:0]         cur;
   event_t             ev;

   assign loading = ~primed;
   assign cur     = {a_db, b_db};
   assign ev      = classify(prev, cur);

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk   (clk),
      .reset (reset),
      .x_in  (a_in),
      .load  (loading),
      .x_s   (a_s),
      .x_db  (a_db)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk   (clk),
      .reset (reset),
      .x_in  (b_in),
      .load  (loading),
      .x_s   (b_s),
      .x_db  (b_db)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         primed    <= 1'b0;
         prime_cnt <= '0;
         prev      <= S00;
         step      <= 1'b0;
         err       <= 1'b0;
         dir       <= 1'b0;
         count     <= '0;
      end else begin
         step <= 1'b0;
         err  <= 1'b0;
         if (!primed) begin
            prev <= {a_s, b_s};
            if (prime_cnt == PRIME_W'(PRIME_CYCLES - 1))
               primed <= 1'b1;
            else
               prime_cnt <= prime_cnt + 1'b1;
         end else begin
            prev <= cur;
            case (ev)
               EV_UP: begin
                  step  <= 1'b1;
                  dir   <= 1'b1;
                  count <= count + 1'b1;
               end
               EV_DOWN: begin
                  step  <= 1'b1;
                  dir   <= 1'b0;
                  count <= count - 1'b1;
               end
               EV_ILLEGAL: err <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
